alu_sequencer: RTL

Multi-cycle arithmetic controller that sits beside the combinational ARITHMETIC datapath. It accepts one operation at a time (two 4-bit nibble operands plus an opcode) through a START/BUSY/DONE handshake. Add and subtract are registered single-step operations. Multiply (true 4x4 shift-add) and divide (restoring) are sequenced over N iterations. The 10-bit result keeps the ARITHMETIC result-bus format, so downstream display logic is unchanged.

---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle arithmetic controller with a START/BUSY/DONE handshake.
// Accepts one operation at a time on two N-bit operands packed as NUMBER = {A, B}.
// Add and subtract complete after one EXEC cycle. Multiply (shift-add) and divide
// (restoring) run N EXEC cycles. Divide by zero flags DIV_ERR after one EXEC cycle.
// The RW-bit result keeps the ARITHMETIC result-bus format.
//
// Ports:
//   CLOCK    in   rising-edge system clock
//   RESET    in   synchronous, active-high reset; aborts any operation in flight
//   START    in   request, sampled only in IDLE
//   NUMBER   in   {A, B} operands, captured on accept
//   OP       in   00 add, 01 subtract, 10 multiply, 11 divide; captured on accept
//   BUSY     out  high whenever the sequencer is not idle
//   DONE     out  one-cycle pulse when F / DIV_ERR are newly valid
//   F        out  result, held until the next result is loaded
//   DIV_ERR  out  divide-by-zero flag, valid with DONE and held with F
module alu_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned RW = 10
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           START,
  input  logic [2*N-1:0] NUMBER,
  input  logic [1:0]     OP,
  output logic           BUSY,
  output logic           DONE,
  output logic [RW-1:0]  F,
  output logic           DIV_ERR
);

  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastIter = CW'(N - 1);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N:0]      rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [RW-1:0]   f_q, f_d;
  logic            div_err_q, div_err_d;

  // Datapath helpers, all derived from the latched operands.
  logic [N:0]      sum;
  logic            a_ge_b;
  logic [N-1:0]    diff_mag;
  logic [2*N-1:0]  mul_addend;
  logic [2*N-1:0]  acc_next;
  logic [CW-1:0]   div_idx;
  logic [N+1:0]    shifted;
  logic [N+1:0]    trial;
  logic            trial_ok;
  logic [N:0]      rem_next;
  logic [N-1:0]    quo_next;

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    a_ge_b   = (a_q >= b_q);
    diff_mag = a_ge_b ? (a_q - b_q) : (b_q - a_q);

    // Multiplier bit cnt_q selects whether A << cnt_q joins the accumulator.
    mul_addend = b_q[cnt_q] ? ({{N{1'b0}}, a_q} << cnt_q) : '0;
    acc_next   = acc_q + mul_addend;

    // Restoring division: bring down dividend bits MSB first; the extra top bit
    // of the trial difference is the sign of the trial subtraction.
    div_idx  = LastIter - cnt_q;
    shifted  = {rem_q, a_q[div_idx]};
    trial    = shifted - {2'b00, b_q};
    trial_ok = ~trial[N+1];
    rem_next = trial_ok ? trial[N:0] : shifted[N:0];
    quo_next = N'({quo_q, trial_ok});
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    f_d       = f_q;
    div_err_d = div_err_q;

    case (state_q)
      StIdle: begin
        if (START) begin
          a_d       = NUMBER[2*N-1:N];
          b_d       = NUMBER[N-1:0];
          op_d      = OP;
          div_err_d = 1'b0;
          cnt_d     = '0;
          acc_d     = '0;
          rem_d     = '0;
          quo_d     = '0;
          state_d   = StExec;
        end
      end

      StExec: begin
        case (op_q)
          OpAdd: begin
            f_d         = '0;
            f_d[N:0]    = sum;
            f_d[RW-1]   = sum[N];
            state_d     = StDone;
          end
          OpSub: begin
            f_d          = '0;
            f_d[N-1:0]   = diff_mag;
            f_d[RW-1]    = ~a_ge_b;
            state_d      = StDone;
          end
          OpMul: begin
            acc_d = acc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LastIter) begin
              f_d          = '0;
              f_d[2*N-1:0] = acc_next;
              state_d      = StDone;
            end
          end
          OpDiv: begin
            if (b_q == '0) begin
              f_d       = '0;
              div_err_d = 1'b1;
              state_d   = StDone;
            end else begin
              rem_d = rem_next;
              quo_d = quo_next;
              cnt_d = cnt_q + CW'(1);
              if (cnt_q == LastIter) begin
                f_d          = '0;
                f_d[2*N-1:0] = {rem_next[N-1:0], quo_next};
                state_d      = StDone;
              end
            end
          end
          default: state_d = StDone;
        endcase
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      f_q       <= '0;
      div_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      f_q       <= f_d;
      div_err_q <= div_err_d;
    end
  end

  assign BUSY    = (state_q != StIdle);
  assign DONE    = (state_q == StDone);
  assign F       = f_q;
  assign DIV_ERR = div_err_q;

endmodule
